// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer feeding the instruction ROM address.
// Tracks IDLE/RUN/HALTED, applies stall/branch/sequential PC updates and counts RUN cycles.
module fetch_pc #(
    parameter int IW         = 9,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic             BranchAbs,
    input  logic [IW-1:0]    Target,
    input  logic [7:0]       Offset,
    output logic [IW-1:0]    InstAddress,
    output logic             Fetching,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic [1:0]       DbgState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [IW-1:0] START_PC = IW'(START_ADDR);

    state_t            state_q, state_d;
    logic [IW-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     rel_target;
    logic              take_branch;

    // Size cast of a signed operand sign-extends the 8-bit offset to IW bits.
    assign rel_target  = pc_q + IW'($signed(Offset));
    assign take_branch = BranchEn && Taken;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (take_branch && BranchAbs) begin
                    pc_d = Target;
                end else if (take_branch) begin
                    pc_d = rel_target;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstAddress = pc_q;
    assign CycleCount  = cnt_q;
    assign Fetching    = (state_q == ST_RUN);
    assign Done        = (state_q == ST_HALTED);
    assign DbgState    = state_q;

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM.
- Drives the ROM read address every cycle and advances it sequentially, on taken branches (absolute or PC-relative), on stalls (hold) and on halt.
- Reports run/done status and a cycle count to the testbench and top level.
- The ROM read is combinational, so InstAddress is the address of the instruction being executed in the current cycle.

Parameters:
- IW, 9, instruction address width; must match the ROM address width; legal range 8..16.
- START_ADDR, 0, PC value loaded at reset and at each Start launch.
- CNT_W, 16, width of CycleCount.

Ports:
- Clk  input  1  clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  launch request; sampled in IDLE and HALTED only.
- Halt  input  1  end-of-program indication from decode; sampled in RUN only.
- Stall  input  1  hold PC this cycle; sampled in RUN only.
- BranchEn  input  1  current instruction is a branch or jump.
- Taken  input  1  branch condition met; meaningful only with BranchEn.
- BranchAbs  input  1  1 = absolute target, 0 = PC-relative offset.
- Target  input  IW  absolute branch target.
- Offset  input  8  signed two's-complement relative displacement.
- InstAddress  output  IW  PC; connects to the ROM address input.
- Fetching  output  1  high while state is RUN.
- Done  output  1  high while state is HALTED.
- CycleCount  output  CNT_W  number of clock edges spent in RUN since the last launch.

Behaviour:
- Reset, synchronous and active-high, overrides everything at any point, including mid-RUN:
  - state = IDLE, InstAddress = START_ADDR, CycleCount = 0.
  - Fetching = 0, Done = 0.
- States are IDLE, RUN and HALTED. Fetching and Done decode directly from the state register and never depend combinationally on inputs.
- IDLE:
  - Start = 1 → RUN at the next edge; PC = START_ADDR, CycleCount = 0.
  - All other inputs are ignored.
- RUN: on each edge CycleCount increments and saturates at all-ones, with no wrap. The next PC uses this strict priority:
  1. Halt = 1 → HALTED; PC holds. This edge is counted.
  2. Stall = 1 → PC holds; state stays RUN.
  3. BranchEn & Taken & BranchAbs → PC = Target.
  4. BranchEn & Taken & !BranchAbs → PC = PC + sign-extend(Offset) to IW bits, modulo 2^IW.
  5. Otherwise → PC = PC + 1 modulo 2^IW. PC = 2^IW−1 wraps to 0.
- A branch with Taken = 0 behaves as rule 5. Taken without BranchEn is ignored.
- Start in RUN is ignored.
- Relative wrap: the result is truncated to IW bits, so a PC at 3 with Offset = −5 (0xFB) gives 2^IW−2.
- HALTED:
  - PC and CycleCount hold; Done = 1.
  - Start = 1 → RUN at the next edge with PC = START_ADDR, CycleCount = 0, Done = 0.
  - Halt, Stall and branch inputs are ignored.
- Reset and Start asserted on the same edge: Reset wins and the block ends in IDLE.
- Latency: the PC update is visible on InstAddress one cycle after the controlling inputs are sampled. There is no combinational path from any input to InstAddress.

Test Plan:
- Reset on two edges, then Start for one cycle, then 5 idle cycles → InstAddress 0,0,1,2,3,4,5; Fetching = 1 from the edge after Start; CycleCount = 5.
- In RUN at PC = 10: BranchEn = 1, Taken = 1, BranchAbs = 1, Target = 200 → next PC 200. Then BranchAbs = 0, Offset = 0xF6 (−10) → next PC 190. Then BranchEn = 1, Taken = 0 → next PC 191.
- PC = 511 with IW = 9 and no branch → PC 0. PC = 2 with Offset = 0xFC (−4), taken → PC 510.
- At PC = 7, assert Stall and BranchEn+Taken together for 3 cycles → PC stays 7 and CycleCount still advances by 3. Release Stall with the branch still taken → PC = Target.
- At PC = 40, assert Halt and Stall together → Done = 1, Fetching = 0, PC stays 40, CycleCount frozen. Start → PC = 0, CycleCount = 0, Done = 0.
- Mid-RUN at PC = 33, assert Reset together with Start → IDLE, PC = 0, CycleCount = 0, Done = 0, Fetching = 0.
- With CNT_W = 4, run 20 cycles → CycleCount saturates at 15.
